// File: rtl/nvram_sync_sequencer_if.sv
// Port-B side bundle of the NVRAM sync sequencer: HPS command pulses, restore/backup
// byte streams, NVRAM port B and CPU access/status lines.
interface nvram_sync_sequencer_if #(
    parameter int unsigned ADDR_W = 13
);
    logic              restore_start;
    logic              restore_skip;
    logic              backup_start;
    logic              rst_valid;
    logic [7:0]        rst_data;
    logic              rst_ready;
    logic              bk_valid;
    logic [7:0]        bk_data;
    logic              bk_ready;
    logic [ADDR_W-1:0] nv_adr;
    logic [7:0]        nv_wdata;
    logic              nv_we;
    logic [7:0]        nv_rdata;
    logic              cpu_changed;
    logic              allow_cpu_access;
    logic              dirty;
    logic              autosave_req;
    logic              busy;
    logic              done;

    modport master (
        input  restore_start, restore_skip, backup_start,
        input  rst_valid, rst_data, bk_ready, nv_rdata, cpu_changed,
        output rst_ready, bk_valid, bk_data, nv_adr, nv_wdata, nv_we,
        output allow_cpu_access, dirty, autosave_req, busy, done
    );

    modport slave (
        output restore_start, restore_skip, backup_start,
        output rst_valid, rst_data, bk_ready, nv_rdata, cpu_changed,
        input  rst_ready, bk_valid, bk_data, nv_adr, nv_wdata, nv_we,
        input  allow_cpu_access, dirty, autosave_req, busy, done
    );
endinterface

// File: rtl/nvram_sync_sequencer.sv
// Owns NVRAM port B: streams HPS restore images in and backups out, gates CPU access,
// tracks CPU-side dirtiness and raises an autosave request once writes have settled.
module nvram_sync_sequencer #(
    parameter int unsigned ADDR_W         = 13,
    parameter int unsigned AUTOSAVE_DELAY = 30_000_000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    nvram_sync_sequencer_if.master bus
);
    localparam int unsigned       TMR_W    = $clog2(AUTOSAVE_DELAY + 1);
    localparam logic [ADDR_W-1:0] LAST_ADR = '1;
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(AUTOSAVE_DELAY);

    typedef enum logic [2:0] {
        S_IDLE, S_RESTORE, S_BK_ADDR, S_BK_LAT, S_BK_OUT, S_FINISH
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_nv_adr;
    logic [7:0]        r_bk_data;
    logic              r_bk_valid, r_rst_ready, r_allow, r_dirty;
    logic              r_autosave_req, r_busy, r_done;
    logic [TMR_W-1:0]  r_tmr;

    logic w_restore_go, w_skip_go, w_backup_go, w_wr_byte;
    logic w_bk_load, w_bk_take, w_adr_inc, w_adr_clr;
    logic w_tmr_run, w_autosave_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state plus per-cycle strobes; commands are only honoured in IDLE.
    always_comb begin
        w_state_nxt  = r_state;
        w_restore_go = 1'b0;
        w_skip_go    = 1'b0;
        w_backup_go  = 1'b0;
        w_wr_byte    = 1'b0;
        w_bk_load    = 1'b0;
        w_bk_take    = 1'b0;
        w_adr_inc    = 1'b0;
        w_adr_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.restore_start) begin
                    w_restore_go = 1'b1;
                    w_state_nxt  = S_RESTORE;
                end else if (bus.restore_skip) begin
                    w_skip_go = 1'b1;
                end else if (bus.backup_start) begin
                    w_backup_go = 1'b1;
                    w_state_nxt = S_BK_ADDR;
                end
            end
            S_RESTORE: begin
                if (bus.rst_valid) begin
                    w_wr_byte = 1'b1;
                    if (r_nv_adr == LAST_ADR) w_state_nxt = S_FINISH;
                    else                      w_adr_inc   = 1'b1;
                end
            end
            S_BK_ADDR: w_state_nxt = S_BK_LAT;
            S_BK_LAT: begin
                w_bk_load   = 1'b1;
                w_state_nxt = S_BK_OUT;
            end
            S_BK_OUT: begin
                if (r_bk_valid && bus.bk_ready) begin
                    w_bk_take = 1'b1;
                    if (r_nv_adr == LAST_ADR) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_adr_inc   = 1'b1;
                        w_state_nxt = S_BK_ADDR;
                    end
                end
            end
            S_FINISH: begin
                w_adr_clr   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Quiet-time countdown only runs while idle with unsaved CPU writes.
    assign w_tmr_run      = r_dirty && (r_state == S_IDLE) && (r_tmr != '0);
    assign w_autosave_set = r_dirty && (r_state == S_IDLE) && !bus.cpu_changed
                            && (r_tmr <= TMR_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_nv_adr       <= '0;
            r_bk_data      <= '0;
            r_bk_valid     <= 1'b0;
            r_rst_ready    <= 1'b0;
            r_allow        <= 1'b0;
            r_dirty        <= 1'b0;
            r_autosave_req <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_tmr          <= '0;
        end else begin
            if (w_restore_go || w_backup_go || w_adr_clr) r_nv_adr <= '0;
            else if (w_adr_inc)                           r_nv_adr <= r_nv_adr + 1'b1;

            if (w_bk_load) begin
                r_bk_data  <= bus.nv_rdata;
                r_bk_valid <= 1'b1;
            end else if (w_bk_take) begin
                r_bk_valid <= 1'b0;
            end

            r_rst_ready <= (w_state_nxt == S_RESTORE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= w_skip_go || (w_state_nxt == S_FINISH);

            if (w_restore_go || w_backup_go)            r_allow <= 1'b0;
            else if (w_skip_go || r_state == S_FINISH) r_allow <= 1'b1;

            // A CPU write outside FINISH always marks dirty, even on the backup_start cycle.
            if (r_state == S_FINISH)                     r_dirty <= 1'b0;
            else if (bus.cpu_changed)                    r_dirty <= 1'b1;
            else if (w_backup_go)                        r_dirty <= 1'b0;

            if (bus.cpu_changed) r_tmr <= TMR_LOAD;
            else if (w_tmr_run)  r_tmr <= r_tmr - 1'b1;

            if (w_backup_go)         r_autosave_req <= 1'b0;
            else if (w_autosave_set) r_autosave_req <= 1'b1;
        end
    end

    assign bus.nv_we            = w_wr_byte;
    assign bus.nv_wdata         = w_wr_byte ? bus.rst_data : 8'h00;
    assign bus.nv_adr           = r_nv_adr;
    assign bus.rst_ready        = r_rst_ready;
    assign bus.bk_valid         = r_bk_valid;
    assign bus.bk_data          = r_bk_data;
    assign bus.allow_cpu_access = r_allow;
    assign bus.dirty            = r_dirty;
    assign bus.autosave_req     = r_autosave_req;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
endmodule

// File: tb/tb_nvram_sync_sequencer.sv
// Bench for nvram_sync_sequencer: command-priority vector table, random-gap restore and
// backpressured backup scoreboarded against a byte-image model, autosave timing, async reset.
`timescale 1ns/1ps
module tb_nvram_sync_sequencer;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned DELAY  = 100;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    nvram_sync_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    nvram_sync_sequencer #(.ADDR_W(ADDR_W), .AUTOSAVE_DELAY(DELAY)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Port-B RAM with registered read, plus a one-cycle bulk preload.
    logic [7:0] ram [DEPTH];
    bit fill_req = 1'b0;
    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < int'(DEPTH); i++) ram[i] <= 8'(i) ^ 8'h5A;
        end else if (bus.nv_we) begin
            ram[bus.nv_adr] <= bus.nv_wdata;
        end
        bus.nv_rdata <= ram[bus.nv_adr];
    end

    // Passive monitor logging writes, backup handshakes, done pulses and hold violations.
    bit                mon_clr = 1'b0;
    logic [ADDR_W-1:0] wr_adr_q[$];
    logic [7:0]        wr_dat_q[$];
    logic [7:0]        bk_q[$];
    int mcyc, done_cnt, done_cyc, last_we_cyc, hold_err;
    logic prev_bv, prev_br;
    logic [7:0] prev_bd;
    always @(negedge clk) begin
        if (mon_clr) begin
            wr_adr_q.delete(); wr_dat_q.delete(); bk_q.delete();
            mcyc = 0; done_cnt = 0; done_cyc = 0; last_we_cyc = 0; hold_err = 0;
            prev_bv = 1'b0; prev_br = 1'b0; prev_bd = 8'h00;
        end else begin
            mcyc++;
            if (bus.nv_we === 1'b1) begin
                wr_adr_q.push_back(bus.nv_adr);
                wr_dat_q.push_back(bus.nv_wdata);
                last_we_cyc = mcyc;
            end
            if (bus.bk_valid && bus.bk_ready) bk_q.push_back(bus.bk_data);
            if (prev_bv && !prev_br && !(bus.bk_valid && bus.bk_data == prev_bd)) hold_err++;
            if (bus.done) begin
                done_cnt++;
                done_cyc = mcyc;
            end
            prev_bv = bus.bk_valid; prev_br = bus.bk_ready; prev_bd = bus.bk_data;
        end
    end

    task automatic clear_inputs();
        bus.restore_start = 1'b0; bus.restore_skip = 1'b0; bus.backup_start = 1'b0;
        bus.rst_valid = 1'b0; bus.rst_data = 8'h00; bus.bk_ready = 1'b0; bus.cpu_changed = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset_n = 1'b0;
        clear_inputs();
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        mon_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Offer one restore byte; acked when rst_ready is seen ahead of an edge.
    task automatic send_byte(input logic [7:0] d, output bit acked);
        bus.rst_valid = 1'b1;
        bus.rst_data  = d;
        acked = 1'b0;
        for (int t = 0; t < 8 && !acked; t++) begin
            @(negedge clk);
            acked = bus.rst_ready;
            tick();
        end
        bus.rst_valid = 1'b0;
    endtask

    function automatic int status4();
        return int'({bus.busy, bus.allow_cpu_access, bus.done, bus.rst_ready});
    endfunction

    function automatic int all_flags();
        return int'({bus.busy, bus.allow_cpu_access, bus.dirty, bus.autosave_req,
                     bus.done, bus.rst_ready, bus.bk_valid, bus.nv_we});
    endfunction

    typedef struct packed {
        logic       rs;
        logic       sk;
        logic       bs;
        logic [3:0] exp;   // {busy, allow_cpu_access, done, rst_ready} one cycle later
    } vec_t;

    vec_t vt[6];

    initial begin
        bit acked, extra_acked, fin, seen;
        int ack_miss, errs, e, t;

        vt[0] = '{1'b0, 1'b0, 1'b0, 4'b0000};
        vt[1] = '{1'b0, 1'b1, 1'b0, 4'b0110};
        vt[2] = '{1'b1, 1'b1, 1'b1, 4'b1001};
        vt[3] = '{1'b0, 1'b1, 1'b1, 4'b0110};
        vt[4] = '{1'b0, 1'b0, 1'b1, 4'b1000};
        vt[5] = '{1'b1, 1'b0, 1'b1, 4'b1001};

        reset_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_flags", all_flags(), 0);
        check("reset_adr", int'(bus.nv_adr), 0);
        tick();
        reset_n = 1'b1;

        // Command priority from IDLE.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            bus.restore_start = vt[i].rs;
            bus.restore_skip  = vt[i].sk;
            bus.backup_start  = vt[i].bs;
            tick();
            clear_inputs();
            @(negedge clk);
            check($sformatf("cmd_vec%0d", i), status4(), int'(vt[i].exp));
            tick();
        end

        // Skip: access granted next cycle, done is a single pulse.
        do_reset();
        bus.restore_skip = 1'b1;
        tick();
        bus.restore_skip = 1'b0;
        @(negedge clk);
        check("skip_grant", status4(), 4'b0110);
        tick();
        @(negedge clk);
        check("skip_done_end", status4(), 4'b0100);
        tick();

        // Restore with random gaps, one extra byte, and an ignored backup_start mid-stream.
        do_reset();
        clear_mon();
        bus.restore_start = 1'b1;
        bus.backup_start  = 1'b1;
        tick();
        bus.restore_start = 1'b0;
        bus.backup_start  = 1'b0;
        ack_miss = 0;
        extra_acked = 1'b0;
        for (int i = 0; i <= int'(DEPTH); i++) begin
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) tick();
            if (i == 3000) begin
                bus.backup_start = 1'b1;
                tick();
                bus.backup_start = 1'b0;
                @(negedge clk);
                check("collision_backup_ignored", int'({bus.busy, bus.rst_ready, bus.bk_valid}), 3'b110);
                tick();
            end
            send_byte(8'(i), acked);
            if (i < int'(DEPTH)) ack_miss += int'(!acked);
            else                 extra_acked = acked;
        end
        repeat (3) tick();
        check("restore_ack_missing", ack_miss, 0);
        check("restore_extra_acked", int'(extra_acked), 0);
        check("restore_write_count", wr_adr_q.size(), int'(DEPTH));
        errs = 0;
        foreach (wr_adr_q[i])
            if (wr_adr_q[i] != ADDR_W'(i) || wr_dat_q[i] != 8'(i)) errs++;
        check("restore_write_errs", errs, 0);
        check("restore_done_count", done_cnt, 1);
        check_range("restore_done_latency", done_cyc - last_we_cyc, 1, 2);
        @(negedge clk);
        check("restore_end_state", int'({bus.busy, bus.allow_cpu_access, bus.rst_ready, bus.dirty}), 4'b0100);
        tick();

        // Backup with ~30% backpressure from a dirty, freshly preloaded RAM.
        bus.cpu_changed = 1'b1;
        tick();
        bus.cpu_changed = 1'b0;
        @(negedge clk);
        check("dirty_set", int'(bus.dirty), 1);
        tick();
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        clear_mon();
        bus.backup_start = 1'b1;
        tick();
        bus.backup_start = 1'b0;
        fin = 1'b0;
        for (int c = 0; c < 60000 && !fin; c++) begin
            bus.bk_ready = ($urandom_range(0, 9) >= 3);
            @(negedge clk);
            fin = bus.done;
            tick();
        end
        bus.bk_ready = 1'b0;
        check("backup_finished", int'(fin), 1);
        check("backup_count", bk_q.size(), int'(DEPTH));
        errs = 0;
        foreach (bk_q[i]) if (bk_q[i] != (8'(i) ^ 8'h5A)) errs++;
        check("backup_data_errs", errs, 0);
        check("backup_hold_errs", hold_err, 0);
        check("backup_done_count", done_cnt, 1);
        @(negedge clk);
        check("backup_end_state", int'({bus.busy, bus.allow_cpu_access, bus.dirty, bus.autosave_req}), 4'b0100);
        tick();

        // Autosave: rises DELAY edges after the last of two CPU writes 50 cycles apart.
        bus.cpu_changed = 1'b1;
        tick();
        bus.cpu_changed = 1'b0;
        repeat (49) tick();
        bus.cpu_changed = 1'b1;
        tick();
        bus.cpu_changed = 1'b0;
        @(negedge clk);
        check("autosave_dirty", int'(bus.dirty), 1);
        e = 50;
        seen = bus.autosave_req;
        while (!seen && e < 400) begin
            tick();
            e++;
            @(negedge clk);
            seen = bus.autosave_req;
        end
        check_range("autosave_rise_edge", e, 50 + int'(DELAY) - 1, 50 + int'(DELAY) + 1);
        repeat (20) tick();
        @(negedge clk);
        check("autosave_held", int'(bus.autosave_req), 1);
        tick();
        clear_mon();
        bus.bk_ready = 1'b1;
        bus.backup_start = 1'b1;
        tick();
        bus.backup_start = 1'b0;
        @(negedge clk);
        check("autosave_cleared", int'({bus.autosave_req, bus.dirty, bus.busy}), 3'b001);
        tick();

        // Async reset at byte 4000 of the backup.
        t = 0;
        while (bk_q.size() < 4000 && t < 20000) begin
            tick();
            t++;
        end
        check("partial_backup_reached", int'(bk_q.size() >= 4000), 1);
        errs = 0;
        foreach (bk_q[i]) if (bk_q[i] != (8'(i) ^ 8'h5A)) errs++;
        check("partial_backup_errs", errs, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_flags", all_flags(), 0);
        check("async_reset_adr", int'(bus.nv_adr), 0);
        check("async_reset_bk_data", int'(bus.bk_data), 0);
        clear_inputs();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("post_reset_idle", int'({bus.busy, bus.allow_cpu_access, bus.bk_valid}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
